// File: rtl/sd_sector_arbiter.sv
// Two-requester front end for the mist_io SD sector port: round-robin grant,
// latched LBA/command, ack-driven handshake with ISSUE timeout, buffer steering.
module sd_sector_arbiter #(
    parameter int TIMEOUT = 50_000_000
) (
    input  logic        clk_sys,
    input  logic        reset,

    input  logic [31:0] req0_lba,
    input  logic        req0_rd,
    input  logic        req0_wr,
    input  logic [7:0]  req0_buff_din,
    output logic        req0_ack,
    output logic        req0_buff_wr,
    output logic        req0_done,
    output logic        req0_err,

    input  logic [31:0] req1_lba,
    input  logic        req1_rd,
    input  logic        req1_wr,
    input  logic [7:0]  req1_buff_din,
    output logic        req1_ack,
    output logic        req1_buff_wr,
    output logic        req1_done,
    output logic        req1_err,

    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic          owner;
    logic          last;
    logic [CW-1:0] cnt;
    logic          ack_m;
    logic          ack_s;

    logic pend0;
    logic pend1;
    logic grant1;
    logic port_busy;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pend0     = req0_rd | req0_wr;
        pend1     = req1_rd | req1_wr;
        grant1    = pend1 & (~pend0 | ~last);
        port_busy = (state == ISSUE) || (state == XFER);
    end

    assign req0_buff_wr = sd_buff_wr & port_busy & ~owner;
    assign req1_buff_wr = sd_buff_wr & port_busy &  owner;
    assign sd_buff_din  = owner ? req1_buff_din : req0_buff_din;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            ack_m     <= 1'b0;
            ack_s     <= 1'b0;
            sd_lba    <= '0;
            sd_rd     <= 1'b0;
            sd_wr     <= 1'b0;
            req0_ack  <= 1'b0;
            req1_ack  <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            req0_err  <= 1'b0;
            req1_err  <= 1'b0;
        end else begin
            ack_m     <= sd_ack;
            ack_s     <= ack_m;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            req0_err  <= 1'b0;
            req1_err  <= 1'b0;

            case (state)
                IDLE: begin
                    if (pend0 | pend1) begin
                        owner <= grant1;
                        last  <= grant1;
                        cnt   <= '0;
                        state <= ISSUE;
                        if (grant1) begin
                            sd_lba <= req1_lba;
                            sd_rd  <= req1_rd;
                            sd_wr  <= req1_wr & ~req1_rd;
                        end else begin
                            sd_lba <= req0_lba;
                            sd_rd  <= req0_rd;
                            sd_wr  <= req0_wr & ~req0_rd;
                        end
                    end
                end

                // An ack that lands on the final count still wins over the abort.
                ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (ack_s) begin
                        state    <= XFER;
                        sd_rd    <= 1'b0;
                        sd_wr    <= 1'b0;
                        req0_ack <= ~owner;
                        req1_ack <=  owner;
                    end else if (cnt == CNT_LAST) begin
                        state    <= ERR;
                        sd_rd    <= 1'b0;
                        sd_wr    <= 1'b0;
                        req0_err <= ~owner;
                        req1_err <=  owner;
                    end
                end

                XFER: begin
                    if (!ack_s) begin
                        state     <= DONE;
                        req0_ack  <= 1'b0;
                        req1_ack  <= 1'b0;
                        req0_done <= ~owner;
                        req1_done <=  owner;
                    end
                end

                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
